// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared bus width, status byte layout and helpers
package sap1_pkg;

    localparam int WORD_W         = 8;
    localparam int STAT_BLOCKED   = 7;
    localparam int STAT_UNDERFLOW = 6;
    localparam int STAT_FULL      = 5;
    localparam int STAT_EMPTY     = 4;
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 3;

    // Occupancy field is 3 bits wide, so deep FIFOs report at most 7.
    function automatic logic [STAT_COUNT_W-1:0] sat_count(input logic [4:0] count);
        return (count > 5'd7) ? 3'd7 : count[STAT_COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with zero-latency head read
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Callers gate push with !full and pop with !empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; its contents are only visible while count > 0.
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/input_port.sv
// rtl/input_port.sv - producer-fed input FIFO driving the W-bus
module input_port
    import sap1_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enable_output,
    input  logic             enable_status,
    output logic [WIDTH-1:0] data_bus_out,
    output logic             bus_drive,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0]  head;
    logic [AW:0]       count;
    logic              push;
    logic              pop;
    logic              status_rd;
    logic              blocked;
    logic              underflow;
    logic [WORD_W-1:0] status;

    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = enable_output && !empty;
    assign status_rd = enable_status && !enable_output;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clock   (Clock),
        .reset   (Reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    // Sticky flags: a status read clears them, but a same-cycle set wins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            blocked   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            blocked   <= (in_valid && full)      || (blocked   && !status_rd);
            underflow <= (enable_output && empty) || (underflow && !status_rd);
        end
    end

    always_comb begin
        status                                   = '0;
        status[STAT_BLOCKED]                     = blocked;
        status[STAT_UNDERFLOW]                   = underflow;
        status[STAT_FULL]                        = full;
        status[STAT_EMPTY]                       = empty;
        status[STAT_COUNT_LSB +: STAT_COUNT_W]   = sat_count(5'(count));
    end

    // Bus mux drives zero when idle so it can be OR-ed with other sources.
    always_comb begin
        bus_drive    = 1'b0;
        data_bus_out = '0;
        if (enable_output) begin
            bus_drive    = 1'b1;
            data_bus_out = empty ? '0 : head;
        end else if (enable_status) begin
            bus_drive    = 1'b1;
            data_bus_out = status;
        end
    end

endmodule

// File: tb/tb_input_port.sv
// tb/tb_input_port.sv - randomized and directed bench for input_port
module tb_input_port;

    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       enable_output = 1'b0;
    logic       enable_status = 1'b0;
    logic [7:0] data_bus_out;
    logic       bus_drive;
    logic       empty;
    logic       full;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_blocked = 0;
    bit         m_underflow = 0;

    input_port #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .enable_output (enable_output),
        .enable_status (enable_status),
        .data_bus_out  (data_bus_out),
        .bus_drive     (bus_drive),
        .empty         (empty),
        .full          (full)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] exp_status();
        int n = q.size();
        int s = (n > 7) ? 7 : n;
        logic [7:0] v;
        v = {m_blocked, m_underflow, (n == DEPTH), (n == 0), 1'b0, 3'(s)};
        return v;
    endfunction

    function automatic logic [7:0] exp_data();
        if (enable_output) return (q.size() > 0) ? q[0] : 8'h00;
        if (enable_status) return exp_status();
        return 8'h00;
    endfunction

    function automatic logic exp_drive();
        return enable_output || enable_status;
    endfunction

    task automatic apply(input logic rst, input logic v, input logic [7:0] d,
                         input logic eo, input logic es);
        Reset = rst; in_valid = v; in_data = d; enable_output = eo; enable_status = es;
    endtask

    // Advance one edge and update the reference from the inputs held across it.
    task automatic tick();
        bit was_full, was_empty, st_rd, do_push, do_pop;
        @(posedge Clock);
        if (Reset) begin
            q.delete();
            m_blocked = 0;
            m_underflow = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            st_rd     = enable_status && !enable_output;
            do_push   = in_valid && !was_full;
            do_pop    = enable_output && !was_empty;
            m_blocked   = (in_valid && was_full) || (m_blocked && !st_rd);
            m_underflow = (enable_output && was_empty) || (m_underflow && !st_rd);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0);
        tick(); tick();
        apply(0, 0, 0, 0, 0);
        @(negedge Clock);
        checks++;
        if (in_ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || bus_drive !== 1'b0 || data_bus_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b emp=%b full=%b drv=%b bus=%h want 1 1 0 0 00",
                     in_ready, empty, full, bus_drive, data_bus_out);
        end
        tick();
        apply(0, 0, 0, 0, 1);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'h10 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL reset_status got %h drv=%b want 10 drv=1", data_bus_out, bus_drive);
        end
        tick();
    endtask

    task automatic test_fifo_order();
        logic [7:0] vals [3] = '{8'hA1, 8'hB2, 8'hC3};
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, vals[i], 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 1, 0);
            @(negedge Clock);
            checks++;
            if (data_bus_out !== vals[i] || bus_drive !== 1'b1) begin
                errors++;
                $display("FAIL order_pop%0d got %h drv=%b want %h drv=1", i, data_bus_out, bus_drive, vals[i]);
            end
            tick();
        end
        apply(0, 0, 0, 0, 0);
        @(negedge Clock);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL order_empty got %b want 1", empty);
        end
    endtask

    task automatic test_full_blocked();
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1, 8'(i), 0, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 8'h05, 0, 0);
            @(negedge Clock);
            checks++;
            if (in_ready !== 1'b0 || full !== 1'b1) begin
                errors++;
                $display("FAIL full_hold%0d got rdy=%b full=%b want 0 1", i, in_ready, full);
            end
            tick();
        end
        apply(0, 0, 0, 0, 1);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'hA4) begin
            errors++;
            $display("FAIL full_status1 got %h want a4", data_bus_out);
        end
        tick();
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'h24) begin
            errors++;
            $display("FAIL full_status2 got %h want 24", data_bus_out);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        for (int i = 0; i < 6; i++) begin
            apply(0, 1, 8'h10 + 8'(i), 1, 0);
            e = exp_data();
            @(negedge Clock);
            checks++;
            if (data_bus_out !== e || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL wrap_pop%0d got %h rdy=%b want %h rdy=0", i, data_bus_out, in_ready, e);
            end
            tick();
            apply(0, 1, 8'h10 + 8'(i), 0, 0);
            @(negedge Clock);
            checks++;
            if (in_ready !== 1'b1 || full !== 1'b0) begin
                errors++;
                $display("FAIL wrap_refill%0d got rdy=%b full=%b want 1 0", i, in_ready, full);
            end
            tick();
        end
        apply(0, 0, 0, 0, 1);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'hA4) begin
            errors++;
            $display("FAIL wrap_status got %h want a4", data_bus_out);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 0);
            e = exp_data();
            @(negedge Clock);
            checks++;
            if (data_bus_out !== e) begin
                errors++;
                $display("FAIL wrap_drain%0d got %h want %h", i, data_bus_out, e);
            end
            tick();
        end
    endtask

    task automatic test_underflow();
        apply(0, 0, 0, 1, 0);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'h00 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL underflow_bus got %h drv=%b want 00 drv=1", data_bus_out, bus_drive);
        end
        tick();
        apply(0, 0, 0, 0, 1);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'h50) begin
            errors++;
            $display("FAIL underflow_status got %h want 50", data_bus_out);
        end
        tick();
        apply(0, 1, 8'h77, 0, 0);
        tick();
        apply(0, 0, 0, 1, 0);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'h77) begin
            errors++;
            $display("FAIL underflow_ptrs got %h want 77", data_bus_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 8'h30 + 8'(i), 0, 0);
            tick();
        end
        apply(1, 1, 8'h99, 1, 0);
        tick();
        apply(0, 0, 0, 0, 1);
        @(negedge Clock);
        checks++;
        if (empty !== 1'b1 || data_bus_out !== 8'h10) begin
            errors++;
            $display("FAIL midreset got emp=%b status=%h want 1 10", empty, data_bus_out);
        end
        tick();
        apply(0, 0, 0, 1, 0);
        @(negedge Clock);
        checks++;
        if (data_bus_out !== 8'h00 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL midreset_underflow got %h drv=%b want 00 drv=1", data_bus_out, bus_drive);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 55), 8'($urandom),
                  ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 25));
            @(negedge Clock);
            if (!Reset) begin
                e = exp_data();
                checks++;
                if (data_bus_out !== e || bus_drive !== exp_drive() ||
                    empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                    in_ready !== (q.size() != DEPTH)) begin
                    errors++;
                    $display("FAIL random%0d got bus=%h drv=%b emp=%b full=%b rdy=%b want bus=%h n=%0d",
                             i, data_bus_out, bus_drive, empty, full, in_ready, e, q.size());
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full_blocked();
        test_wrap();
        test_underflow();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
